// File: rtl/ahblite_pkg.sv
// ---------------------------------------------------------------------------
// ahblite_pkg
// Shared AHB-lite constants and types for the slave-side response mux.
//   HTRANS_* : master transfer-type encodings
//   HRESP_*  : slave response encodings
//   SEL_*    : bit positions inside the one-hot data-phase select register
//   dflt_state_t : default-slave FSM states
//   decode_sel() : address-phase select priority decode
// ---------------------------------------------------------------------------
package ahblite_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    localparam int NUM_PORTS = 4;
    localparam int SEL_P0    = 0;
    localparam int SEL_P1    = 1;
    localparam int SEL_P2    = 2;
    localparam int SEL_P3    = 3;
    localparam int SEL_DFLT  = 4;
    localparam int SEL_W     = 5;

    typedef enum logic [1:0] {
        DS_IDLE = 2'd0,
        DS_ERR1 = 2'd1,
        DS_ERR2 = 2'd2
    } dflt_state_t;

    // Lowest port index wins; an active transfer with no select goes to the
    // default slave, an IDLE/BUSY with no select selects nothing.
    function automatic logic [SEL_W-1:0] decode_sel(
        input logic [NUM_PORTS-1:0] eff_sel,
        input logic [1:0]           htrans
    );
        logic [SEL_W-1:0] sel;
        sel = '0;
        if (eff_sel[SEL_P0])      sel[SEL_P0] = 1'b1;
        else if (eff_sel[SEL_P1]) sel[SEL_P1] = 1'b1;
        else if (eff_sel[SEL_P2]) sel[SEL_P2] = 1'b1;
        else if (eff_sel[SEL_P3]) sel[SEL_P3] = 1'b1;
        else if (htrans == HTRANS_NONSEQ || htrans == HTRANS_SEQ)
            sel[SEL_DFLT] = 1'b1;
        return sel;
    endfunction

endpackage

// File: rtl/ahblite_slave_mux_if.sv
// ---------------------------------------------------------------------------
// ahblite_slave_mux_if
// Bus bundle between the AHB-lite master/decoder/slaves and the response mux.
//   HTRANS            master transfer type (address phase)
//   Pn_HSEL           decoder selects (address phase)
//   Pn_HREADYOUT      slave ready
//   Pn_HRDATA         slave read data
//   Pn_HRESP          slave response
//   HREADY/HRDATA/HRESP  muxed response back to master and slaves
// Modports:
//   master : the surrounding fabric (master, decoder, slaves) driving requests
//   slave  : the response mux itself
// ---------------------------------------------------------------------------
interface ahblite_slave_mux_if;
    logic [1:0]  HTRANS;
    logic        P0_HSEL, P1_HSEL, P2_HSEL, P3_HSEL;
    logic        P0_HREADYOUT, P1_HREADYOUT, P2_HREADYOUT, P3_HREADYOUT;
    logic [31:0] P0_HRDATA, P1_HRDATA, P2_HRDATA, P3_HRDATA;
    logic        P0_HRESP, P1_HRESP, P2_HRESP, P3_HRESP;
    logic        HREADY;
    logic [31:0] HRDATA;
    logic        HRESP;

    modport master (
        output HTRANS,
        output P0_HSEL, P1_HSEL, P2_HSEL, P3_HSEL,
        output P0_HREADYOUT, P1_HREADYOUT, P2_HREADYOUT, P3_HREADYOUT,
        output P0_HRDATA, P1_HRDATA, P2_HRDATA, P3_HRDATA,
        output P0_HRESP, P1_HRESP, P2_HRESP, P3_HRESP,
        input  HREADY, HRDATA, HRESP
    );

    modport slave (
        input  HTRANS,
        input  P0_HSEL, P1_HSEL, P2_HSEL, P3_HSEL,
        input  P0_HREADYOUT, P1_HREADYOUT, P2_HREADYOUT, P3_HREADYOUT,
        input  P0_HRDATA, P1_HRDATA, P2_HRDATA, P3_HRDATA,
        input  P0_HRESP, P1_HRESP, P2_HRESP, P3_HRESP,
        output HREADY, HRDATA, HRESP
    );
endinterface

// File: rtl/ahblite_default_slave.sv
// ---------------------------------------------------------------------------
// ahblite_default_slave
// Two-cycle ERROR responder for unmapped transfers, plus the optional
// stall-abort timer (enabled by defining AHB_MUX_TIMEOUT_EN).
// Ports:
//   HCLK, HRESETn   clock, async active-low reset
//   hready_i        current bus HREADY
//   dflt_sel_i      address phase decodes to the default slave
//   stall_i         selected real slave is holding HREADYOUT low
//   err_active_o    FSM owns the response (ERR1/ERR2)
//   err_hready_o    HREADY to present while err_active_o
//   err_hresp_o     HRESP to present while err_active_o
//   takeover_o      stall abort this cycle; mux must drop its select
//   timeout_irq_o   one-cycle pulse during the abort's ERR1 cycle
//
// state   | meaning
// --------+------------------------------------------------------------
// DS_IDLE | no error response in progress
// DS_ERR1 | first ERROR cycle: HREADY=0, HRESP=1
// DS_ERR2 | second ERROR cycle: HREADY=1, HRESP=1, next address sampled
// ---------------------------------------------------------------------------
module ahblite_default_slave
    import ahblite_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic HCLK,
    input  logic HRESETn,
    input  logic hready_i,
    input  logic dflt_sel_i,
    input  logic stall_i,
    output logic err_active_o,
    output logic err_hready_o,
    output logic err_hresp_o,
    output logic takeover_o,
    output logic timeout_irq_o
);

    dflt_state_t state_q;
    logic        err_active_q;
    logic        err_hready_q;
    logic        err_hresp_q;
    logic        irq_q;
    logic        accept_dflt;
    logic        timeout_hit;

    assign accept_dflt = hready_i & dflt_sel_i;

`ifdef AHB_MUX_TIMEOUT_EN
    // Abort fires on the stall cycle that brings the count to TIMEOUT_CYCLES.
    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] cnt_q, cnt_d;

    assign timeout_hit = stall_i && (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (hready_i || timeout_hit) cnt_d = '0;
        else if (stall_i)            cnt_d = cnt_q + 16'd1;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end
`else
    localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;
    logic unused_stall;
    assign unused_stall = stall_i;
    assign timeout_hit  = 1'b0;
`endif

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q      <= DS_IDLE;
            err_active_q <= 1'b0;
            err_hready_q <= 1'b1;
            err_hresp_q  <= HRESP_OKAY;
            irq_q        <= 1'b0;
        end else begin
            irq_q <= timeout_hit;
            unique case (state_q)
                DS_IDLE, DS_ERR2: begin
                    if (accept_dflt || timeout_hit) begin
                        state_q      <= DS_ERR1;
                        err_active_q <= 1'b1;
                        err_hready_q <= 1'b0;
                        err_hresp_q  <= HRESP_ERROR;
                    end else begin
                        state_q      <= DS_IDLE;
                        err_active_q <= 1'b0;
                        err_hready_q <= 1'b1;
                        err_hresp_q  <= HRESP_OKAY;
                    end
                end
                DS_ERR1: begin
                    state_q      <= DS_ERR2;
                    err_active_q <= 1'b1;
                    err_hready_q <= 1'b1;
                    err_hresp_q  <= HRESP_ERROR;
                end
                default: begin
                    state_q      <= DS_IDLE;
                    err_active_q <= 1'b0;
                    err_hready_q <= 1'b1;
                    err_hresp_q  <= HRESP_OKAY;
                end
            endcase
        end
    end

    assign err_active_o  = err_active_q;
    assign err_hready_o  = err_hready_q;
    assign err_hresp_o   = err_hresp_q;
    assign takeover_o    = timeout_hit;
    assign timeout_irq_o = irq_q;

endmodule

// File: rtl/ahblite_slave_mux.sv
// ---------------------------------------------------------------------------
// ahblite_slave_mux
// AHB-lite response mux: registers the decoder's one-hot select in the
// address phase and returns the selected slave's HREADYOUT/HRDATA/HRESP in
// the data phase. Unmapped active transfers get a two-cycle ERROR from the
// built-in default slave. Optional stall abort with AHB_MUX_TIMEOUT_EN.
// Parameters:
//   Port0_en..Port3_en  port present; a disabled port's HSEL is ignored
//   TIMEOUT_CYCLES      stall limit (2..65535), only with AHB_MUX_TIMEOUT_EN
// Ports:
//   HCLK, HRESETn  clock, async active-low reset
//   bus            ahblite_slave_mux_if.slave (requests in, response out)
//   TIMEOUT_IRQ    one-cycle pulse on stall abort (0 without the macro)
// ---------------------------------------------------------------------------
module ahblite_slave_mux
    import ahblite_pkg::*;
#(
    parameter bit          Port0_en       = 1'b1,
    parameter bit          Port1_en       = 1'b1,
    parameter bit          Port2_en       = 1'b1,
    parameter bit          Port3_en       = 1'b1,
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic               HCLK,
    input  logic               HRESETn,
    ahblite_slave_mux_if.slave bus,
    output logic               TIMEOUT_IRQ
);

    localparam logic [NUM_PORTS-1:0] PORT_EN = {Port3_en, Port2_en, Port1_en, Port0_en};

    logic [NUM_PORTS-1:0] hsel_v;
    logic [NUM_PORTS-1:0] hreadyout_v;
    logic [NUM_PORTS-1:0] hresp_v;
    logic [31:0]          hrdata_v [NUM_PORTS];
    logic [NUM_PORTS-1:0] eff_sel;
    logic [SEL_W-1:0]     addr_sel;
    logic [SEL_W-1:0]     sel_q, sel_d;

    logic        hready_mux;
    logic        hresp_mux;
    logic [31:0] hrdata_mux;
    logic        slave_stall;

    logic err_active, err_hready, err_hresp, takeover;

    assign hsel_v      = {bus.P3_HSEL, bus.P2_HSEL, bus.P1_HSEL, bus.P0_HSEL};
    assign hreadyout_v = {bus.P3_HREADYOUT, bus.P2_HREADYOUT, bus.P1_HREADYOUT, bus.P0_HREADYOUT};
    assign hresp_v     = {bus.P3_HRESP, bus.P2_HRESP, bus.P1_HRESP, bus.P0_HRESP};
    assign hrdata_v[0] = bus.P0_HRDATA;
    assign hrdata_v[1] = bus.P1_HRDATA;
    assign hrdata_v[2] = bus.P2_HRDATA;
    assign hrdata_v[3] = bus.P3_HRDATA;

    assign eff_sel  = hsel_v & PORT_EN;
    assign addr_sel = decode_sel(eff_sel, bus.HTRANS);

    // A stall abort drops the slave for good; otherwise load only on HREADY.
    always_comb begin
        sel_d = sel_q;
        if (takeover)        sel_d = '0;
        else if (hready_mux) sel_d = addr_sel;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) sel_q <= '0;
        else          sel_q <= sel_d;
    end

    // The error FSM owns the response for default-slave transfers and for
    // the two cycles following a stall abort (sel_q is already zero then).
    always_comb begin
        hready_mux = 1'b1;
        hresp_mux  = HRESP_OKAY;
        hrdata_mux = '0;
        if (err_active || sel_q[SEL_DFLT]) begin
            hready_mux = err_hready;
            hresp_mux  = err_hresp;
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (sel_q[i]) begin
                    hready_mux = hreadyout_v[i];
                    hresp_mux  = hresp_v[i];
                    hrdata_mux = hrdata_v[i];
                end
            end
        end
    end

    assign slave_stall = !err_active && (|sel_q[SEL_P3:SEL_P0]) && !hready_mux;

    ahblite_default_slave #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_dflt (
        .HCLK          (HCLK),
        .HRESETn       (HRESETn),
        .hready_i      (hready_mux),
        .dflt_sel_i    (addr_sel[SEL_DFLT]),
        .stall_i       (slave_stall),
        .err_active_o  (err_active),
        .err_hready_o  (err_hready),
        .err_hresp_o   (err_hresp),
        .takeover_o    (takeover),
        .timeout_irq_o (TIMEOUT_IRQ)
    );

    assign bus.HREADY = hready_mux;
    assign bus.HRDATA = hrdata_mux;
    assign bus.HRESP  = hresp_mux;

endmodule

// File: tb/tb_ahblite_slave_mux.sv
module tb_ahblite_slave_mux;
    import ahblite_pkg::*;

    localparam int TO_CYC = 4;

    logic        HCLK;
    logic        HRESETn;
    logic [1:0]  htrans;
    logic [3:0]  hsel, rdyout, resp;
    logic [31:0] rdata [4];
    logic        irq0, irq2;

    int errors = 0;
    int checks = 0;

    ahblite_slave_mux_if bus0();
    ahblite_slave_mux_if bus2();

    ahblite_slave_mux #(.Port0_en(1'b1), .Port1_en(1'b1), .Port2_en(1'b1), .Port3_en(1'b1),
                        .TIMEOUT_CYCLES(TO_CYC))
        dut0 (.HCLK(HCLK), .HRESETn(HRESETn), .bus(bus0), .TIMEOUT_IRQ(irq0));

    ahblite_slave_mux #(.Port0_en(1'b1), .Port1_en(1'b1), .Port2_en(1'b0), .Port3_en(1'b1),
                        .TIMEOUT_CYCLES(TO_CYC))
        dut2 (.HCLK(HCLK), .HRESETn(HRESETn), .bus(bus2), .TIMEOUT_IRQ(irq2));

    assign bus0.HTRANS = htrans;          assign bus2.HTRANS = htrans;
    assign bus0.P0_HSEL = hsel[0];        assign bus2.P0_HSEL = hsel[0];
    assign bus0.P1_HSEL = hsel[1];        assign bus2.P1_HSEL = hsel[1];
    assign bus0.P2_HSEL = hsel[2];        assign bus2.P2_HSEL = hsel[2];
    assign bus0.P3_HSEL = hsel[3];        assign bus2.P3_HSEL = hsel[3];
    assign bus0.P0_HREADYOUT = rdyout[0]; assign bus2.P0_HREADYOUT = rdyout[0];
    assign bus0.P1_HREADYOUT = rdyout[1]; assign bus2.P1_HREADYOUT = rdyout[1];
    assign bus0.P2_HREADYOUT = rdyout[2]; assign bus2.P2_HREADYOUT = rdyout[2];
    assign bus0.P3_HREADYOUT = rdyout[3]; assign bus2.P3_HREADYOUT = rdyout[3];
    assign bus0.P0_HRESP = resp[0];       assign bus2.P0_HRESP = resp[0];
    assign bus0.P1_HRESP = resp[1];       assign bus2.P1_HRESP = resp[1];
    assign bus0.P2_HRESP = resp[2];       assign bus2.P2_HRESP = resp[2];
    assign bus0.P3_HRESP = resp[3];       assign bus2.P3_HRESP = resp[3];
    assign bus0.P0_HRDATA = rdata[0];     assign bus2.P0_HRDATA = rdata[0];
    assign bus0.P1_HRDATA = rdata[1];     assign bus2.P1_HRDATA = rdata[1];
    assign bus0.P2_HRDATA = rdata[2];     assign bus2.P2_HRDATA = rdata[2];
    assign bus0.P3_HRDATA = rdata[3];     assign bus2.P3_HRDATA = rdata[3];

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    // {HREADY, HRESP, HRDATA}
    localparam logic [33:0] OK0 = {1'b1, 1'b0, 32'h0};
    localparam logic [33:0] E1  = {1'b0, 1'b1, 32'h0};
    localparam logic [33:0] E2  = {1'b1, 1'b1, 32'h0};

    typedef struct {
        logic [1:0]  trans;
        logic [3:0]  sel;
        logic [3:0]  rdy;
        logic [3:0]  rsp;
        logic [33:0] exp0;
        logic [33:0] exp2;
    } vec_t;

    localparam int NV = 23;
    vec_t vecs [NV];

    // Transaction-level reference: who owns the current data phase
    // (-1 nobody, 0..3 a port, 4 the error responder) and which error cycle.
    int         m_owner [2];
    int         m_err   [2];
    logic [3:0] m_en    [2];
    int         stall_run [2];

    function automatic vec_t mk(logic [1:0] t, logic [3:0] s, logic [3:0] r,
                                logic [3:0] p, logic [33:0] e0, logic [33:0] e2);
        vec_t v;
        v.trans = t; v.sel = s; v.rdy = r; v.rsp = p; v.exp0 = e0; v.exp2 = e2;
        return v;
    endfunction

    task automatic drive(logic [1:0] t, logic [3:0] s, logic [3:0] r, logic [3:0] p);
        htrans = t; hsel = s; rdyout = r; resp = p;
    endtask

    task automatic fixed_data();
        rdata[0] = 32'h1; rdata[1] = 32'hCAFE_0001; rdata[2] = 32'h2; rdata[3] = 32'h3;
    endtask

    task automatic check(input string name, input logic [34:0] act, input logic [34:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [33:0] model_resp(int k);
        if (m_owner[k] < 0)  return OK0;
        if (m_owner[k] == 4) return (m_err[k] != 0) ? E2 : E1;
        return {rdyout[m_owner[k]], resp[m_owner[k]], rdata[m_owner[k]]};
    endfunction

    task automatic model_step(int k, logic ready);
        if (ready) begin
            m_owner[k] = -1;
            m_err[k]   = 0;
            for (int i = 3; i >= 0; i--)
                if (hsel[i] && m_en[k][i]) m_owner[k] = i;
            if (m_owner[k] < 0 && htrans[1]) m_owner[k] = 4;
        end else if (m_owner[k] == 4) begin
            m_err[k] = 1;
        end
    endtask

    initial begin
        logic [33:0] e;
        m_en[0] = 4'b1111;
        m_en[1] = 4'b1011;

        vecs[0]  = mk(HTRANS_IDLE,   4'h0, 4'hF, 4'h0, OK0, OK0);
        vecs[1]  = mk(HTRANS_NONSEQ, 4'h2, 4'hF, 4'h0, OK0, OK0);
        vecs[2]  = mk(HTRANS_IDLE,   4'h0, 4'hD, 4'h0, {2'b00, 32'hCAFE_0001}, {2'b00, 32'hCAFE_0001});
        vecs[3]  = mk(HTRANS_IDLE,   4'h0, 4'hD, 4'h0, {2'b00, 32'hCAFE_0001}, {2'b00, 32'hCAFE_0001});
        vecs[4]  = mk(HTRANS_IDLE,   4'h0, 4'hF, 4'h0, {2'b10, 32'hCAFE_0001}, {2'b10, 32'hCAFE_0001});
        vecs[5]  = mk(HTRANS_NONSEQ, 4'h0, 4'hF, 4'h0, OK0, OK0);
        vecs[6]  = mk(HTRANS_IDLE,   4'h0, 4'hF, 4'h0, E1, E1);
        vecs[7]  = mk(HTRANS_IDLE,   4'h0, 4'hF, 4'h0, E2, E2);
        vecs[8]  = mk(HTRANS_IDLE,   4'h0, 4'hF, 4'h0, OK0, OK0);
        vecs[9]  = mk(HTRANS_NONSEQ, 4'h1, 4'hF, 4'h0, OK0, OK0);
        vecs[10] = mk(HTRANS_NONSEQ, 4'h8, 4'hF, 4'h0, {2'b10, 32'h1}, {2'b10, 32'h1});
        vecs[11] = mk(HTRANS_IDLE,   4'h0, 4'hF, 4'h0, {2'b10, 32'h3}, {2'b10, 32'h3});
        vecs[12] = mk(HTRANS_NONSEQ, 4'h0, 4'hF, 4'h0, OK0, OK0);
        vecs[13] = mk(HTRANS_NONSEQ, 4'h0, 4'hF, 4'h0, E1, E1);
        vecs[14] = mk(HTRANS_SEQ,    4'h0, 4'hF, 4'h0, E2, E2);
        vecs[15] = mk(HTRANS_NONSEQ, 4'h4, 4'hF, 4'h0, E1, E1);
        vecs[16] = mk(HTRANS_NONSEQ, 4'h4, 4'hF, 4'h0, E2, E2);
        vecs[17] = mk(HTRANS_IDLE,   4'h0, 4'hF, 4'h4, {2'b11, 32'h2}, E1);
        vecs[18] = mk(HTRANS_NONSEQ, 4'h3, 4'hF, 4'h0, OK0, E2);
        vecs[19] = mk(HTRANS_IDLE,   4'h0, 4'hE, 4'h0, {2'b00, 32'h1}, {2'b00, 32'h1});
        vecs[20] = mk(HTRANS_IDLE,   4'h0, 4'hF, 4'h0, {2'b10, 32'h1}, {2'b10, 32'h1});
        vecs[21] = mk(HTRANS_BUSY,   4'h0, 4'hF, 4'h0, OK0, OK0);
        vecs[22] = mk(HTRANS_IDLE,   4'h0, 4'hF, 4'h0, OK0, OK0);

        // Reset held with a select and a stalled P1 on the bus.
        HRESETn = 1'b0;
        fixed_data();
        drive(HTRANS_NONSEQ, 4'h2, 4'hD, 4'h0);
        repeat (3) begin
            @(negedge HCLK);
            check("reset dut0", {bus0.HREADY, bus0.HRESP, bus0.HRDATA, irq0}, {OK0, 1'b0});
            check("reset dut2", {bus2.HREADY, bus2.HRESP, bus2.HRDATA, irq2}, {OK0, 1'b0});
        end
        drive(HTRANS_IDLE, 4'h0, 4'hD, 4'h0);
        HRESETn = 1'b1;
        @(negedge HCLK);
        check("post-reset idle", {1'b0, bus0.HREADY, bus0.HRESP, bus0.HRDATA}, {1'b0, OK0});
        @(posedge HCLK); #1;

        for (int r = 0; r < NV; r++) begin
            drive(vecs[r].trans, vecs[r].sel, vecs[r].rdy, vecs[r].rsp);
            @(negedge HCLK);
            check($sformatf("vec%0d dut0", r), {1'b0, bus0.HREADY, bus0.HRESP, bus0.HRDATA}, {1'b0, vecs[r].exp0});
            check($sformatf("vec%0d dut2", r), {1'b0, bus2.HREADY, bus2.HRESP, bus2.HRDATA}, {1'b0, vecs[r].exp2});
            @(posedge HCLK); #1;
        end

        // Asynchronous reset in the middle of a P1 wait state.
        drive(HTRANS_NONSEQ, 4'h2, 4'hF, 4'h0);
        @(posedge HCLK); #1;
        drive(HTRANS_IDLE, 4'h0, 4'hD, 4'h0);
        @(negedge HCLK);
        check("wait before reset", {34'h0, bus0.HREADY}, 35'h0);
        #2 HRESETn = 1'b0;
        #1;
        check("async reset dut0", {bus0.HREADY, bus0.HRESP, bus0.HRDATA, irq0}, {OK0, 1'b0});
        check("async reset dut2", {bus2.HREADY, bus2.HRESP, bus2.HRDATA, irq2}, {OK0, 1'b0});
        @(negedge HCLK);
        drive(HTRANS_IDLE, 4'h0, 4'hF, 4'h0);
        HRESETn = 1'b1;
        @(posedge HCLK); #1;

        // Random traffic against the reference model.
        for (int k = 0; k < 2; k++) begin
            m_owner[k] = -1; m_err[k] = 0; stall_run[k] = 0;
        end
        for (int c = 0; c < 400; c++) begin
            htrans = 2'($urandom_range(0, 3));
            for (int i = 0; i < 4; i++) begin
                hsel[i]   = ($urandom_range(0, 3) == 0);
                rdyout[i] = ($urandom_range(0, 3) != 0);
                resp[i]   = ($urandom_range(0, 7) == 0);
                rdata[i]  = $urandom;
            end
            // Keep stalls short so a timeout build never aborts here.
            if (stall_run[0] >= 3 || stall_run[1] >= 3) rdyout = 4'hF;
            @(negedge HCLK);
            for (int k = 0; k < 2; k++) begin
                e = model_resp(k);
                if (k == 0)
                    check($sformatf("rand%0d dut0", c), {bus0.HREADY, bus0.HRESP, bus0.HRDATA, irq0}, {e, 1'b0});
                else
                    check($sformatf("rand%0d dut2", c), {bus2.HREADY, bus2.HRESP, bus2.HRDATA, irq2}, {e, 1'b0});
                if (m_owner[k] >= 0 && m_owner[k] < 4 && !e[33]) stall_run[k]++;
                else stall_run[k] = 0;
                model_step(k, e[33]);
            end
            @(posedge HCLK); #1;
        end

        fixed_data();
        drive(HTRANS_IDLE, 4'h0, 4'hF, 4'h0);
        repeat (3) @(posedge HCLK);
        #1;

`ifdef AHB_MUX_TIMEOUT_EN
        // P0 stuck low: four stall cycles, then ERR1 with IRQ, then ERR2.
        drive(HTRANS_NONSEQ, 4'h1, 4'hF, 4'h0);
        @(posedge HCLK); #1;
        drive(HTRANS_IDLE, 4'h0, 4'hE, 4'h0);
        for (int i = 0; i < TO_CYC; i++) begin
            @(negedge HCLK);
            check($sformatf("to stall%0d", i), {bus0.HREADY, bus0.HRESP, bus0.HRDATA, irq0}, {2'b00, 32'h1, 1'b0});
            @(posedge HCLK); #1;
        end
        @(negedge HCLK);
        check("to err1", {bus0.HREADY, bus0.HRESP, bus0.HRDATA, irq0}, {E1, 1'b1});
        @(posedge HCLK); #1;
        drive(HTRANS_NONSEQ, 4'h2, 4'hE, 4'h0);
        @(negedge HCLK);
        check("to err2", {bus0.HREADY, bus0.HRESP, bus0.HRDATA, irq0}, {E2, 1'b0});
        @(posedge HCLK); #1;
        drive(HTRANS_IDLE, 4'h0, 4'hE, 4'h0);
        @(negedge HCLK);
        check("to p1 after", {bus0.HREADY, bus0.HRESP, bus0.HRDATA, irq0}, {2'b10, 32'hCAFE_0001, 1'b0});
        @(posedge HCLK); #1;

        // Reset asserted during a stall.
        drive(HTRANS_NONSEQ, 4'h1, 4'hF, 4'h0);
        @(posedge HCLK); #1;
        drive(HTRANS_IDLE, 4'h0, 4'hE, 4'h0);
        @(negedge HCLK);
        check("to stall pre-reset", {34'h0, bus0.HREADY}, 35'h0);
        #2 HRESETn = 1'b0;
        #1;
        check("to stall reset", {bus0.HREADY, bus0.HRESP, bus0.HRDATA, irq0}, {OK0, 1'b0});
        @(negedge HCLK);
        HRESETn = 1'b1;
        @(posedge HCLK); #1;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
